// File: rtl/counter_header_parser_pkg.sv
// Shared framing constants for the counter-header record, used by both the
// header writer and this parser.
package counter_header_parser_pkg;

    localparam logic [15:0] EVT_HDR_WORD  = 16'hAAAA;
    localparam logic [15:0] DATA_HDR_WORD = 16'hDDDD;
    localparam int          HDR_FIELD_CNT = 12;

    localparam int IDX_HDR       = 0;
    localparam int IDX_PPS       = 1;
    localparam int IDX_TENMHZ_HI = 2;
    localparam int IDX_EVENT_HI  = 4;
    localparam int IDX_TRIG_HI   = 6;
    localparam int IDX_CLOCK_HI  = 8;
    localparam int IDX_CLOCK_LO  = 11;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/counter_header_parser_byte_to_word_packer.sv
// Packs bytes into big-endian 16-bit words. In slide mode every byte after the
// first completes a word, giving a two-byte sliding window for sync hunting.
module byte_to_word_packer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr,
    input  logic        slide,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic        word_stb,
    output logic [15:0] word
);

    logic [7:0] hi_byte;
    logic       phase;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hi_byte <= '0;
            phase   <= 1'b0;
        end else if (clr) begin
            hi_byte <= '0;
            phase   <= 1'b0;
        end else if (byte_vld) begin
            hi_byte <= byte_in;
            phase   <= slide | ~phase;
        end
    end

    assign word_stb = byte_vld & phase;
    assign word     = {hi_byte, byte_in};

endmodule

// File: rtl/counter_header_parser.sv
// Parses the counter-header byte stream into PPS/10MHz/EVENT/TRIG/CLOCK
// counters, with AA AA sync hunting, trailer checking and a valid/ack output.
module counter_header_parser
    import counter_header_parser_pkg::*;
#(
    parameter int TRAILER_WORDS = 4,
    parameter int ERRCNT_W      = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENABLE,
    output logic                CFIFO_RDEN,
    input  logic [7:0]          CFIFO_DOUT,
    input  logic                CFIFO_EMPTY,
    input  logic                CFIFO_VALID,
    output logic                HDR_VALID,
    input  logic                HDR_ACK,
    output logic [15:0]         PPS_COUNT,
    output logic [31:0]         TENMHZ_COUNT,
    output logic [31:0]         EVENT_COUNT,
    output logic [31:0]         TRIG_COUNT,
    output logic [63:0]         CLOCK_COUNT,
    output logic                HDR_ERR,
    output logic [ERRCNT_W-1:0] ERR_COUNT,
    output logic                SYNCED
);

    localparam int REC_WORDS = HDR_FIELD_CNT + TRAILER_WORDS;
    localparam int REC_BYTES = 2 * REC_WORDS;
    localparam int ISS_W     = $clog2(REC_BYTES + 1);
    localparam int WIDX_W    = $clog2(REC_WORDS);

    localparam logic [ISS_W-1:0]  ISS_LIMIT   = ISS_W'(REC_BYTES);
    localparam logic [ISS_W-1:0]  ISS_SYNCED  = ISS_W'(2);
    localparam logic [WIDX_W-1:0] WIDX_HDR    = WIDX_W'(IDX_HDR);
    localparam logic [WIDX_W-1:0] WIDX_FIRST  = WIDX_W'(IDX_PPS);
    localparam logic [WIDX_W-1:0] WIDX_FLAST  = WIDX_W'(IDX_CLOCK_LO);
    localparam logic [WIDX_W-1:0] WIDX_TRAIL  = WIDX_W'(HDR_FIELD_CNT);
    localparam logic [WIDX_W-1:0] WIDX_LAST   = WIDX_W'(REC_WORDS - 1);

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic [ISS_W-1:0]  issued;
    logic [WIDX_W-1:0] widx;
    logic              rd_pend;
    logic [15:0]       field_sh [IDX_PPS:IDX_CLOCK_LO];

    logic        hunting;
    logic        word_stb;
    logic [15:0] word;
    logic        hunt_match, coll_stb, frame_err, rec_done, ack_take, pk_clr, rd_perm;

    assign hunting = (state == ST_HUNT);
    assign SYNCED  = (state != ST_HUNT);

    byte_to_word_packer u_packer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (pk_clr),
        .slide    (hunting),
        .byte_vld (CFIFO_VALID),
        .byte_in  (CFIFO_DOUT),
        .word_stb (word_stb),
        .word     (word)
    );

    always_comb begin
        hunt_match = hunting && word_stb && (word == EVT_HDR_WORD);
        coll_stb   = (state == ST_COLLECT) && word_stb;
        frame_err  = coll_stb && (((widx == WIDX_HDR) && (word != EVT_HDR_WORD)) ||
                                  ((widx >= WIDX_TRAIL) && (word != DATA_HDR_WORD)));
        rec_done   = coll_stb && (widx == WIDX_LAST) && (word == DATA_HDR_WORD);
        ack_take   = (state == ST_HOLD) && HDR_ACK;
        pk_clr     = hunt_match | frame_err | ack_take;
        // Hunting keeps at most one read in flight so the window never races ahead of sync.
        rd_perm = 1'b0;
        case (state)
            ST_HUNT:    rd_perm = ~rd_pend;
            ST_COLLECT: rd_perm = (issued < ISS_LIMIT);
            default:    rd_perm = 1'b0;
        endcase
        CFIFO_RDEN = RST_N & ENABLE & ~CFIFO_EMPTY & rd_perm;
    end

    always_ff @(posedge CLK) begin
        if (coll_stb && (widx >= WIDX_FIRST) && (widx <= WIDX_FLAST))
            field_sh[widx] <= word;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_HUNT;
            issued       <= '0;
            widx         <= '0;
            rd_pend      <= 1'b0;
            HDR_VALID    <= 1'b0;
            HDR_ERR      <= 1'b0;
            ERR_COUNT    <= '0;
            PPS_COUNT    <= '0;
            TENMHZ_COUNT <= '0;
            EVENT_COUNT  <= '0;
            TRIG_COUNT   <= '0;
            CLOCK_COUNT  <= '0;
        end else begin
            HDR_ERR <= frame_err;
            rd_pend <= CFIFO_RDEN;
            if (frame_err)
                ERR_COUNT <= sat_inc(ERR_COUNT);
            case (state)
                ST_HUNT: begin
                    if (hunt_match) begin
                        state  <= ST_COLLECT;
                        issued <= ISS_SYNCED;
                        widx   <= WIDX_FIRST;
                    end
                end
                ST_COLLECT: begin
                    if (CFIFO_RDEN)
                        issued <= issued + 1'b1;
                    if (frame_err) begin
                        state <= ST_HUNT;
                    end else if (rec_done) begin
                        state        <= ST_HOLD;
                        HDR_VALID    <= 1'b1;
                        PPS_COUNT    <= field_sh[IDX_PPS];
                        TENMHZ_COUNT <= {field_sh[IDX_TENMHZ_HI], field_sh[IDX_TENMHZ_HI+1]};
                        EVENT_COUNT  <= {field_sh[IDX_EVENT_HI], field_sh[IDX_EVENT_HI+1]};
                        TRIG_COUNT   <= {field_sh[IDX_TRIG_HI], field_sh[IDX_TRIG_HI+1]};
                        CLOCK_COUNT  <= {field_sh[IDX_CLOCK_HI],   field_sh[IDX_CLOCK_HI+1],
                                         field_sh[IDX_CLOCK_HI+2], field_sh[IDX_CLOCK_HI+3]};
                    end else if (coll_stb) begin
                        widx <= widx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // After ack the next record's AA AA is checked in place, not hunted.
                    if (HDR_ACK) begin
                        state     <= ST_COLLECT;
                        HDR_VALID <= 1'b0;
                        issued    <= '0;
                        widx      <= WIDX_HDR;
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_header_parser.sv
// Randomized scoreboard bench for counter_header_parser: a byte-stream model of
// the framing rules predicts decoded records and error counts.
module tb_counter_header_parser;

    localparam int TW = 4;
    localparam int EW = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          ENABLE = 1'b0;
    logic          CFIFO_RDEN;
    logic [7:0]    CFIFO_DOUT = 8'h00;
    logic          CFIFO_EMPTY = 1'b1;
    logic          CFIFO_VALID = 1'b0;
    logic          HDR_VALID;
    logic          HDR_ACK = 1'b0;
    logic [15:0]   PPS_COUNT;
    logic [31:0]   TENMHZ_COUNT, EVENT_COUNT, TRIG_COUNT;
    logic [63:0]   CLOCK_COUNT;
    logic          HDR_ERR;
    logic [EW-1:0] ERR_COUNT;
    logic          SYNCED;

    counter_header_parser #(.TRAILER_WORDS(TW), .ERRCNT_W(EW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .CFIFO_RDEN(CFIFO_RDEN),
        .CFIFO_DOUT(CFIFO_DOUT), .CFIFO_EMPTY(CFIFO_EMPTY), .CFIFO_VALID(CFIFO_VALID),
        .HDR_VALID(HDR_VALID), .HDR_ACK(HDR_ACK), .PPS_COUNT(PPS_COUNT),
        .TENMHZ_COUNT(TENMHZ_COUNT), .EVENT_COUNT(EVENT_COUNT), .TRIG_COUNT(TRIG_COUNT),
        .CLOCK_COUNT(CLOCK_COUNT), .HDR_ERR(HDR_ERR), .ERR_COUNT(ERR_COUNT), .SYNCED(SYNCED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pps;
        logic [31:0] tm;
        logic [31:0] ev;
        logic [31:0] tr;
        logic [63:0] ck;
    } rec_t;

    logic [7:0] fifo_q[$];
    rec_t       exp_q[$];

    int total = 0, bad = 0;
    int rden_cnt = 0, rden_viol = 0, deliv = 0;
    int err_seen = 0, rec_seen = 0;
    int ack_delay = 2;
    bit rnd_io = 0, mon_busy = 0;

    // reference model state: byte-stream view of the framing rules
    int          m_st, m_k, m_errcnt, m_err_pulses = 0;
    bit          m_have, m_phase;
    logic [7:0]  m_prev, m_hi;
    logic [15:0] m_w [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_have = 0; m_phase = 0; m_k = 0; m_errcnt = 0;
    endtask

    task automatic model_err();
        m_err_pulses++;
        if (m_errcnt < ERR_MAX) m_errcnt++;
        m_st = 0; m_have = 0; m_phase = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] w;
        rec_t r;
        if (m_st == 0) begin
            if (m_have && m_prev == 8'hAA && b == 8'hAA) begin
                m_st = 1; m_k = 1; m_phase = 0;
            end else begin
                m_prev = b; m_have = 1;
            end
        end else if (!m_phase) begin
            m_hi = b; m_phase = 1;
        end else begin
            m_phase = 0;
            w = {m_hi, b};
            m_w[m_k] = w;
            if (m_k == 0) begin
                if (w != 16'hAAAA) model_err(); else m_k = 1;
            end else if (m_k < 12) begin
                m_k++;
            end else if (w != 16'hDDDD) begin
                model_err();
            end else if (m_k == 11 + TW) begin
                r.pps = m_w[1];
                r.tm  = {m_w[2], m_w[3]};
                r.ev  = {m_w[4], m_w[5]};
                r.tr  = {m_w[6], m_w[7]};
                r.ck  = {m_w[8], m_w[9], m_w[10], m_w[11]};
                exp_q.push_back(r);
                m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    function automatic logic [7:0] rbyte();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == 8'hAA) ? 8'h55 : b;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.pps = {rbyte(), rbyte()};
        r.tm  = {rbyte(), rbyte(), rbyte(), rbyte()};
        r.ev  = {rbyte(), rbyte(), rbyte(), rbyte()};
        r.tr  = {rbyte(), rbyte(), rbyte(), rbyte()};
        r.ck  = {rbyte(), rbyte(), rbyte(), rbyte(), rbyte(), rbyte(), rbyte(), rbyte()};
        return r;
    endfunction

    task automatic push_word(input logic [15:0] w);
        fifo_q.push_back(w[15:8]);
        fifo_q.push_back(w[7:0]);
    endtask

    task automatic push_record(input rec_t r, input bit bad3);
        push_word(16'hAAAA);
        push_word(r.pps);
        push_word(r.tm[31:16]); push_word(r.tm[15:0]);
        push_word(r.ev[31:16]); push_word(r.ev[15:0]);
        push_word(r.tr[31:16]); push_word(r.tr[15:0]);
        push_word(r.ck[63:48]); push_word(r.ck[47:32]);
        push_word(r.ck[31:16]); push_word(r.ck[15:0]);
        for (int i = 0; i < TW; i++)
            push_word((bad3 && i == 2) ? 16'hDDDC : 16'hDDDD);
    endtask

    // FIFO read-port model; bytes reach the reference model when the DUT consumes them
    initial begin
        bit rden_s;
        forever begin
            @(negedge CLK);
            if (RST_N && CFIFO_VALID) model_byte(CFIFO_DOUT);
            rden_s = CFIFO_RDEN;
            if (rden_s && (CFIFO_EMPTY || !ENABLE)) rden_viol++;
            if (rden_s) rden_cnt++;
            @(posedge CLK);
            #1;
            if (rden_s && fifo_q.size() > 0) begin
                CFIFO_DOUT  = fifo_q.pop_front();
                CFIFO_VALID = 1'b1;
                deliv++;
            end else begin
                CFIFO_VALID = 1'b0;
            end
            ENABLE      = rnd_io ? ($urandom_range(0, 3) != 0) : 1'b1;
            CFIFO_EMPTY = (fifo_q.size() == 0) || (rnd_io && $urandom_range(0, 2) == 0);
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RST_N && HDR_ERR) err_seen++;
    end

    // record monitor: pops the scoreboard on every presented record
    initial begin
        rec_t         r;
        logic [175:0] snap;
        bit           stable;
        forever begin
            @(negedge CLK);
            if (RST_N && HDR_VALID) begin
                mon_busy = 1;
                rec_seen++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_record actual=pps_%0h required=none", PPS_COUNT);
                end else begin
                    r = exp_q.pop_front();
                    chk("pps",    64'(PPS_COUNT),    64'(r.pps));
                    chk("tenmhz", 64'(TENMHZ_COUNT), 64'(r.tm));
                    chk("event",  64'(EVENT_COUNT),  64'(r.ev));
                    chk("trig",   64'(TRIG_COUNT),   64'(r.tr));
                    chk("clock",  CLOCK_COUNT,       r.ck);
                end
                snap = {PPS_COUNT, TENMHZ_COUNT, EVENT_COUNT, TRIG_COUNT, CLOCK_COUNT};
                stable = 1;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge CLK);
                    if (CFIFO_RDEN || !HDR_VALID ||
                        snap != {PPS_COUNT, TENMHZ_COUNT, EVENT_COUNT, TRIG_COUNT, CLOCK_COUNT})
                        stable = 0;
                end
                chk("hold_stable", 64'(stable), 64'd1);
                HDR_ACK = 1'b1;
                @(negedge CLK);
                HDR_ACK = 1'b0;
                mon_busy = 0;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},  64'(HDR_VALID),    64'd0);
        chk({tag, "_err"},    64'(HDR_ERR),      64'd0);
        chk({tag, "_synced"}, 64'(SYNCED),       64'd0);
        chk({tag, "_errcnt"}, 64'(ERR_COUNT),    64'd0);
        chk({tag, "_rden"},   64'(CFIFO_RDEN),   64'd0);
        chk({tag, "_pps"},    64'(PPS_COUNT),    64'd0);
        chk({tag, "_tenmhz"}, 64'(TENMHZ_COUNT), 64'd0);
        chk({tag, "_event"},  64'(EVENT_COUNT),  64'd0);
        chk({tag, "_trig"},   64'(TRIG_COUNT),   64'd0);
        chk({tag, "_clock"},  CLOCK_COUNT,       64'd0);
    endtask

    task automatic reset_dut(input string tag);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_zero(tag);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        for (int pass = 0; pass < 2; pass++) begin
            while ((fifo_q.size() != 0 || exp_q.size() != 0 || mon_busy || HDR_VALID) && t < 30000) begin
                @(posedge CLK);
                t++;
            end
            repeat (8) @(posedge CLK);
        end
        chk({"drain_timeout_", nm}, 64'(t >= 30000), 64'd0);
    endtask

    initial begin
        rec_t r1;
        int   base, t, e0, n0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;

        // known record, FIFO never empty once loaded
        r1.pps = 16'h0005; r1.tm = 32'h00989680; r1.ev = 32'h1; r1.tr = 32'h2;
        r1.ck = 64'h0123456789ABCDEF;
        rden_cnt = 0;
        push_record(r1, 0);
        drain("known");
        chk("rden_pulses", 64'(rden_cnt), 64'd32);
        chk("no_err_known", 64'(err_seen), 64'd0);
        chk("records_known", 64'(rec_seen), 64'd1);

        // long hold with a second record queued behind it
        ack_delay = 50;
        push_record(rand_rec(), 0);
        push_record(rand_rec(), 0);
        drain("hold");
        ack_delay = 2;
        chk("records_hold", 64'(rec_seen), 64'd3);

        // junk prefix before sync
        reset_dut("rst2");
        fifo_q.push_back(8'h12); fifo_q.push_back(8'hAA); fifo_q.push_back(8'h34);
        push_record(rand_rec(), 0);
        drain("junk");
        chk("records_junk", 64'(rec_seen), 64'd4);
        chk("errcnt_junk", 64'(ERR_COUNT), 64'd0);

        // corrupted third trailer word, then a clean record
        e0 = err_seen;
        push_record(rand_rec(), 1);
        push_record(rand_rec(), 0);
        drain("trailer");
        chk("err_pulse_once", 64'(err_seen - e0), 64'd1);
        chk("errcnt_one", 64'(ERR_COUNT), 64'd1);
        chk("records_trailer", 64'(rec_seen), 64'd5);

        // random EMPTY / ENABLE gaps
        rnd_io = 1;
        rden_viol = 0;
        for (int i = 0; i < 3; i++) push_record(rand_rec(), 0);
        drain("gaps");
        rnd_io = 0;
        chk("rden_rule", 64'(rden_viol), 64'd0);
        chk("records_gaps", 64'(rec_seen), 64'd8);

        // reset part-way through a record
        base = deliv;
        push_record(rand_rec(), 0);
        t = 0;
        do begin
            @(posedge CLK);
            #2;
            t++;
        end while (deliv < base + 17 && t < 2000);
        chk("rst_wait_timeout", 64'(t >= 2000), 64'd0);
        RST_N = 1'b0;
        model_reset();
        #1;
        check_zero("midrst");
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        n0 = rec_seen;
        push_record(rand_rec(), 0);
        drain("after_rst");
        chk("records_after_rst", 64'(rec_seen - n0), 64'd1);

        // 300 framing errors saturate the counter
        for (int i = 0; i < 300; i++) begin
            push_word(16'hAAAA);
            for (int j = 0; j < 24; j++) fifo_q.push_back(8'h00);
        end
        e0 = err_seen;
        drain("saturate");
        chk("err_pulses_sat", 64'(err_seen - e0), 64'd300);
        chk("errcnt_sat", 64'(ERR_COUNT), 64'(ERR_MAX));
        chk("errcnt_model", 64'(ERR_COUNT), 64'(m_errcnt));
        chk("err_pulses_model", 64'(err_seen), 64'(m_err_pulses));
        chk("rden_rule_all", 64'(rden_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
